mult_issue_ctrl: RTL and testbench
==================================

# mult_issue_ctrl

Issue-and-writeback stage wrapped around the 32x32 unsigned multiplier `umultiplier`. It accepts a multiply request from the execute pipeline and supports both signed and unsigned operands by converting signed operands to magnitudes. It holds those magnitudes stable on the multiplier inputs for the multiplier's fixed latency, then sign-corrects the 64-bit product and commits it to HI/LO result registers with a one-cycle `done` pulse.

## Interface
- `LATENCY`, default 4: rising `clk` edges `umultiplier` needs from stable inputs to a valid `out`. Legal range is 1..15.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — request strobe; sampled only while `busy`=0.
- `is_signed`  in  1  — 1 = two's-complement operands, 0 = unsigned.
- `in1`  in  32  — multiplicand, sampled with `start`.
- `in2`  in  32  — multiplier operand, sampled with `start`.
- `busy`  out  1  — an operation is in flight.
- `done`  out  1  — one-cycle pulse; `hi`/`lo` are updated in that same cycle.
- `hi`  out  32  — product bits [63:32].
- `lo`  out  32  — product bits [31:0].

## Operation
- States:
  - IDLE: `busy`=0.
  - WAIT: `busy`=1; a cycle counter runs.
  - FIX: `busy`=1; sign correction and commit.
- IDLE → WAIT on an edge with `start`=1. On that edge the block latches:
  - `a_mag` = (`is_signed` & `in1[31]`) ? −`in1` : `in1`, as 32-bit unsigned. −2^31 maps to 0x80000000, which is correct as a magnitude.
  - `b_mag` from `in2`, by the same rule.
  - `neg` = `is_signed` & (`in1[31]` ^ `in2[31]`).
  - counter = `LATENCY`−1.
- `a_mag`/`b_mag` drive the `umultiplier` inputs directly from registers. They stay constant from the latch edge until the next accepted `start`.
- WAIT: the counter decrements on each edge. On the edge where counter = 0, the block captures the multiplier `out` into the 64-bit `prod` register and moves to FIX.
- FIX: one cycle, then back to IDLE.
  - `{hi,lo}` ← `neg` ? (~`prod` + 1) : `prod`, using full 64-bit negation.
  - `done` is asserted for exactly this cycle.
- Zero product with `neg`=1 negates to 0. No special case is needed.
- `hi`/`lo` hold their last committed value until the next FIX. They never show partial results.
- `start` while `busy`=1 is ignored: no queuing, no error, and operands are not re-latched.
- `start` may be asserted in the cycle immediately after `done`, since the block is already IDLE then.

## Timing
- Reset values (asynchronous, immediate on `rst`=1):
  - state = IDLE
  - `busy`=0, `done`=0
  - `hi`=0, `lo`=0
  - `a_mag`=0, `b_mag`=0, `prod`=0, `neg`=0, counter=0
- Reset mid-operation aborts the operation. `hi`/`lo` go to 0, not to the previous result. No `done` is produced for the aborted operation.
- Latency: `start` accepted at edge k.
  - `busy` is high from after edge k through edge k+`LATENCY`+1.
  - `done` is high for the cycle after edge k+`LATENCY`+1, when `busy` is 0 again.
- Throughput: one operation per `LATENCY`+2 cycles when `start` is held high.
- `done` and `busy` are registered outputs with no combinational path from `start`.

## Structure
- Package `mult_pkg`:
  - `WORD`=32 and `DWORD`=64.
  - State enum {IDLE, WAIT, FIX}.
  - Counter width constant of 4 bits.
- One sub-module: `umultiplier`, instantiated as-is, with ports `clk`, `in1`, `in2`, `out`.
- Magnitude/negate logic stays inline; it is only two conditional negations and one 64-bit negation.

## Test plan
- Unsigned max: `is_signed`=0, `in1`=`in2`=0xFFFFFFFF → `done` at k+`LATENCY`+2, `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Signed mixed: `is_signed`=1, `in1`=−3 (0xFFFFFFFD), `in2`=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- Signed corner: `is_signed`=1, `in1`=`in2`=0x80000000 → `hi`=0x40000000, `lo`=0; also −1×0 → `hi`=`lo`=0.
- Busy rejection: accept 7×6, pulse `start` with 9×9 two cycles later → exactly one `done`, `lo`=42; then issue `start` in the cycle right after `done` and check it is accepted.
- Reset mid-op: assert `rst` during WAIT after a prior result of 42 → `busy`/`done`/`hi`/`lo` go to 0 immediately and no `done` follows release.
- Same-operand signedness check: 0xFFFFFFFF×2 gives `hi`=0x00000001, `lo`=0xFFFFFFFE when `is_signed`=0, and `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE when `is_signed`=1.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and state encoding for the multiply issue stage
package mult_pkg;
  localparam int WORD  = 32;
  localparam int DWORD = 64;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FIX
  } state_e;
endpackage

// File: rtl/umultiplier.sv
// rtl/umultiplier.sv - 32x32 unsigned pipelined multiplier, LATENCY edges input-to-out
module umultiplier #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [63:0] out
);
  logic [63:0] prod;

  assign prod = {32'd0, in1} * {32'd0, in2};

  // The edge that loads the operand registers upstream counts as the first stage,
  // so only LATENCY-1 register stages live here.
  generate
    if (LATENCY <= 1) begin : g_comb
      assign out = prod;
    end else begin : g_pipe
      logic [63:0] pipe_q [LATENCY-1];

      always_ff @(posedge clk) begin
        pipe_q[0] <= prod;
        for (int i = 1; i < LATENCY - 1; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign out = pipe_q[LATENCY-2];
    end
  endgenerate
endmodule

// File: rtl/mult_issue_ctrl.sv
// rtl/mult_issue_ctrl.sv - signed/unsigned issue, wait and HI/LO writeback around umultiplier
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic [WORD-1:0] in1,
  input  logic [WORD-1:0] in2,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] hi,
  output logic [WORD-1:0] lo
);
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [WORD-1:0]     a_mag_q, b_mag_q;
  logic                neg_q;
  logic [DWORD-1:0]    prod_q;
  logic [DWORD-1:0]    mul_out;
  logic [WORD-1:0]     hi_q, lo_q;
  logic                done_q;
  logic                accept;

  assign accept = (state_q == IDLE) && start;

  umultiplier #(.LATENCY(LATENCY)) u_mul (
    .clk (clk),
    .in1 (a_mag_q),
    .in2 (b_mag_q),
    .out (mul_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_mag_q <= '0;
      b_mag_q <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        // -0x80000000 wraps to 0x80000000, which is already the right magnitude
        a_mag_q <= (is_signed && in1[WORD-1]) ? -in1 : in1;
        b_mag_q <= (is_signed && in2[WORD-1]) ? -in2 : in2;
        neg_q   <= is_signed && (in1[WORD-1] ^ in2[WORD-1]);
        cnt_q   <= CNT_W'(LATENCY - 1);
      end
      if (state_q == WAIT) begin
        if (cnt_q == '0) prod_q <= mul_out;
        else             cnt_q  <= cnt_q - CNT_W'(1);
      end
      if (state_q == FIX) begin
        {hi_q, lo_q} <= neg_q ? (~prod_q + DWORD'(1)) : prod_q;
        done_q       <= 1'b1;
      end
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb/tb_mult_issue_ctrl.sv - self-checking bench for mult_issue_ctrl
module tb_mult_issue_ctrl;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_issue_ctrl #(.LATENCY(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .in1       (in1),
    .in2       (in2),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Issues one request from a post-edge sample point and waits for done.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [63:0] res, output int cyc, output logic busy1);
    start = 1'b1; in1 = a; in2 = b; is_signed = s;
    @(posedge clk); #1;
    start = 1'b0;
    in1 = $urandom; in2 = $urandom; is_signed = ~s;
    busy1 = busy;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    res = {hi, lo};
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_checked(input string name, input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] res, exp;
    int cyc;
    logic b1;
    exp = ref_mul(a, b, s);
    do_op(a, b, s, res, cyc, b1);
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL %s result got %h expected %h", name, res, exp);
    end
    checks++;
    if (cyc !== L + 1 || b1 !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s timing cyc=%0d busy_after_accept=%b busy_at_done=%b expected %0d/1/0", name, cyc, b1, busy, L + 1);
    end
  endtask

  task automatic test_directed();
    logic [63:0] res;
    int cyc;
    logic b1;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, cyc, b1);
    checks++;
    if (res !== 64'hFFFF_FFFE_0000_0001 || cyc !== L + 1) begin
      errors++;
      $display("FAIL unsigned_max got %h cyc=%0d expected fffffffe00000001 cyc=%0d", res, cyc, L + 1);
    end
    do_op(32'hFFFF_FFFD, 32'd5, 1'b1, res, cyc, b1);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      errors++;
      $display("FAIL signed_mixed got %h expected ffffffffffffff f1", res);
    end
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, res, cyc, b1);
    checks++;
    if (res !== 64'h4000_0000_0000_0000) begin
      errors++;
      $display("FAIL signed_min_sq got %h expected 4000000000000000", res);
    end
    do_op(32'hFFFF_FFFF, 32'd0, 1'b1, res, cyc, b1);
    checks++;
    if (res !== 64'd0) begin
      errors++;
      $display("FAIL neg_zero got %h expected 0", res);
    end
    do_op(32'hFFFF_FFFF, 32'd2, 1'b0, res, cyc, b1);
    checks++;
    if (res !== 64'h0000_0001_FFFF_FFFE) begin
      errors++;
      $display("FAIL unsigned_x2 got %h expected 00000001fffffffe", res);
    end
    do_op(32'hFFFF_FFFF, 32'd2, 1'b1, res, cyc, b1);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++;
      $display("FAIL signed_x2 got %h expected fffffffffffffffe", res);
    end
  endtask

  task automatic test_busy_reject();
    int n, dones, cyc;
    start = 1'b1; in1 = 32'd7; in2 = 32'd6; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; in1 = 32'd9; in2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    n = 2; dones = 0;
    while (n < L + 1) begin
      if (done) dones++;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (dones !== 0 || done !== 1'b1 || hi !== 32'd0 || lo !== 32'd42) begin
      errors++;
      $display("FAIL busy_reject early_dones=%0d done=%b hi=%h lo=%h expected 0/1/0/2a", dones, done, hi, lo);
    end
    start = 1'b1; in1 = 32'd3; in2 = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_after_done busy=%b done=%b expected 1/0", busy, done);
    end
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== L + 1 || lo !== 32'd12 || hi !== 32'd0) begin
      errors++;
      $display("FAIL start_after_done_result cyc=%0d lo=%h expected %0d/c", cyc, lo, L + 1);
    end
  endtask

  task automatic test_reset_midop();
    logic [63:0] res;
    int cyc;
    logic b1;
    int bad;
    do_op(32'd7, 32'd6, 1'b0, res, cyc, b1);
    start = 1'b1; in1 = 32'd5; in2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (res !== 64'd42 || {busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset_midop prior=%h busy=%b done=%b hi=%h lo=%h expected 2a then zeros", res, busy, done, hi, lo);
    end
    @(negedge clk); rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 2 * L + 6; i++) begin
      @(posedge clk); #1;
      if (done || busy || hi != 0 || lo != 0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_no_done bad_cycles=%0d expected 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    localparam int P = L + 2;
    localparam int N = 3 * P + 3;
    logic [31:0] ra [N];
    logic [31:0] rb [N];
    logic        rs [N];
    logic        exp_done;
    logic [63:0] exp;
    int j;
    for (int e = 0; e < N; e++) begin
      ra[e] = $urandom; rb[e] = $urandom; rs[e] = 1'($urandom_range(0, 1));
      start = (e <= 2 * P);
      in1 = ra[e]; in2 = rb[e]; is_signed = rs[e];
      @(posedge clk); #1;
      exp_done = (e >= L + 1) && ((e - (L + 1)) % P == 0) && ((e - (L + 1)) / P <= 2);
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL b2b_done edge=%0d got %b expected %b", e, done, exp_done);
      end
      if (exp_done) begin
        j = ((e - (L + 1)) / P) * P;
        exp = ref_mul(ra[j], rb[j], rs[j]);
        checks++;
        if ({hi, lo} !== exp) begin
          errors++;
          $display("FAIL b2b_result edge=%0d got %h expected %h", e, {hi, lo}, exp);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [31:0] corners [4];
    corners[0] = 32'h0; corners[1] = 32'h8000_0000; corners[2] = 32'hFFFF_FFFF; corners[3] = 32'h7FFF_FFFF;
    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 32'($urandom);
      run_checked("random", a, b, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_reject();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
